// File: rtl/cnt10_key_ctrl_pkg.sv
// Shared encodings for the cnt10 key controller: FSM states, key indices,
// and the fixed press-priority encoder.
package cnt10_key_ctrl_pkg;

    localparam int unsigned NKEY  = 4;
    localparam int unsigned TMR_W = 24;
    localparam int unsigned DB_W  = 20;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_HOLD     = 3'd2,
        ST_REPEAT   = 3'd3,
        ST_RELEASE  = 3'd4
    } state_e;

    typedef logic [1:0] key_idx_t;

    localparam key_idx_t K_ADD1  = 2'd0;
    localparam key_idx_t K_ADD10 = 2'd1;
    localparam key_idx_t K_SUB1  = 2'd2;
    localparam key_idx_t K_SUB10 = 2'd3;

    // Same priority the counter applies: +1 > +10 > -1 > -10.
    function automatic key_idx_t key_prio(input logic [NKEY-1:0] keys);
        if (keys[K_ADD1])       return K_ADD1;
        else if (keys[K_ADD10]) return K_ADD10;
        else if (keys[K_SUB1])  return K_SUB1;
        else                    return K_SUB10;
    endfunction

endpackage

// File: rtl/cnt10_key_ctrl_key_sync.sv
// Two-flop synchroniser for the raw active-low buttons; resets to released (1).
module cnt10_key_ctrl_key_sync
    import cnt10_key_ctrl_pkg::*;
(
    input  logic            RSTX,
    input  logic            CLK,
    input  logic [NKEY-1:0] keyx,
    output logic [NKEY-1:0] sync_q
);

    logic [NKEY-1:0] meta_q;
    logic [NKEY-1:0] meta_d;
    logic [NKEY-1:0] sync_d;

    always_comb begin
        meta_d = keyx;
        sync_d = meta_q;
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

endmodule

// File: rtl/cnt10_key_ctrl.sv
// Debounce, arbitration and auto-repeat sequencing for the four counter keys;
// emits at most one registered one-cycle command pulse per clock.
module cnt10_key_ctrl
    import cnt10_key_ctrl_pkg::*;
#(
    parameter logic [19:0] DB_CYC  = 20'd500000,
    parameter logic [23:0] RPT_DLY = 24'd12500000,
    parameter logic [23:0] RPT_PER = 24'd2500000
) (
    input  logic            RSTX,
    input  logic            CLK,
    input  logic            EN,
    input  logic [NKEY-1:0] KEYX,
    output logic            ADD1,
    output logic            ADD10,
    output logic            SUB1,
    output logic            SUB10,
    output logic            BUSY
);

    localparam logic [TMR_W-1:0] DB_LAST  = TMR_W'(DB_CYC) - TMR_W'(1);
    localparam logic [TMR_W-1:0] DLY_LAST = RPT_DLY - TMR_W'(1);
    localparam logic [TMR_W-1:0] PER_LAST = RPT_PER - TMR_W'(1);

    logic [NKEY-1:0]  sync_q;
    logic [NKEY-1:0]  key_s;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    key_idx_t         sel_q, sel_d;
    logic [NKEY-1:0]  cmd_q, cmd_d;
    logic             busy_q, busy_d;
    logic             fire;
    logic             sel_held;

    cnt10_key_ctrl_key_sync u_key_sync (
        .RSTX   (RSTX),
        .CLK    (CLK),
        .keyx   (KEYX),
        .sync_q (sync_q)
    );

    assign key_s    = ~sync_q;
    assign sel_held = key_s[sel_q];

    // Next-state, shared timer and pulse decode.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        sel_d   = sel_q;
        fire    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (|key_s) begin
                    sel_d   = key_prio(key_s);
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (!sel_held) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q == DB_LAST) begin
                    fire    = 1'b1;
                    state_d = ST_HOLD;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_HOLD: begin
                fire = (timer_q == DLY_LAST);
                if (!sel_held) begin
                    state_d = ST_RELEASE;
                    timer_d = '0;
                end else if (fire) begin
                    state_d = ST_REPEAT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_REPEAT: begin
                fire = (timer_q == PER_LAST);
                if (!sel_held) begin
                    state_d = ST_RELEASE;
                    timer_d = '0;
                end else if (fire) begin
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RELEASE: begin
                // Any press, even a bounce spike, restarts the quiet window.
                if (|key_s) begin
                    timer_d = '0;
                end else if (timer_q == DB_LAST) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        if (!EN) begin
            state_d = ST_IDLE;
            timer_d = '0;
            fire    = 1'b0;
        end

        cmd_d  = fire ? (NKEY'(1) << sel_q) : '0;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            sel_q   <= K_ADD1;
            cmd_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            sel_q   <= sel_d;
            cmd_q   <= cmd_d;
            busy_q  <= busy_d;
        end
    end

    assign ADD1  = cmd_q[K_ADD1];
    assign ADD10 = cmd_q[K_ADD10];
    assign SUB1  = cmd_q[K_SUB1];
    assign SUB10 = cmd_q[K_SUB10];
    assign BUSY  = busy_q;

endmodule

// File: doc/cnt10_key_ctrl.md
Name: cnt10_key_ctrl

Overview:
- Front-end controller for the BER-test decimal setting counter (+1/+10/-1/-10 counter with upper bound).
- Takes four raw push-button inputs and synchronises and debounces them.
- Arbitrates between simultaneous presses and sequences single-step plus auto-repeat command pulses into the counter's ADD1/ADD10/SUB1/SUB10 inputs.
- Guarantees at most one command pulse per cycle, so the counter never sees competing commands.

Parameters:
- DB_CYC, 20'd500000: debounce length in CLK cycles (press and release); must be >= 2.
- RPT_DLY, 24'd12500000: hold time after the first pulse before auto-repeat starts; must be >= 2.
- RPT_PER, 24'd2500000: auto-repeat period in cycles; must be >= 2.

Ports:
- RSTX  input   1  asynchronous active-low reset
- CLK   input   1  clock
- EN    input   1  controller enable; low forces idle
- KEYX  input   4  raw buttons, active-low, asynchronous; [0]=+1, [1]=+10, [2]=-1, [3]=-10
- ADD1  output  1  one-cycle command pulse to counter
- ADD10 output  1  one-cycle command pulse
- SUB1  output  1  one-cycle command pulse
- SUB10 output  1  one-cycle command pulse
- BUSY  output  1  high whenever state != IDLE

Behaviour:
- Reset: RSTX asynchronous, active-low; clock CLK. All outputs 0, state IDLE, timers 0, synchroniser flops 1 (released).
- Input path: two-flop synchroniser per key; key_s = ~sync2 (1 = pressed). All decisions use key_s only.
- Outputs are registered and one-hot or zero; a pulse lasts exactly one cycle.
- Timer: one shared 24-bit up-counter. It is cleared on every state change and never wraps, since its max value is bounded by the parameters.
- State IDLE:
  - If any key_s is set, latch the index sel by fixed priority +1 > +10 > -1 > -10 (same priority the counter applies), then go to DEBOUNCE.
- State DEBOUNCE:
  - If key_s[sel] is 0, return to IDLE with no pulse (glitch rejected).
  - Otherwise the timer increments. When timer == DB_CYC-1, emit the pulse for sel and go to HOLD.
- State HOLD:
  - If key_s[sel] is 0, go to RELEASE.
  - When timer == RPT_DLY-1, emit a pulse and go to REPEAT.
- State REPEAT:
  - If key_s[sel] is 0, go to RELEASE.
  - Otherwise emit a pulse each time timer == RPT_PER-1, then clear the timer.
- State RELEASE:
  - Requires all four key_s == 0 for DB_CYC consecutive cycles; any press restarts the timer. Then go to IDLE.
  - This prevents bounce on release from producing a second step.
- Other keys: pressed while sel is held, they are ignored. A new key only becomes effective after RELEASE completes and it is still held in IDLE.
- Latency: raw KEYX[k] asserted and sampled at edge N, held stable, gives the first pulse visible after edge N+3+DB_CYC-1. The bench checks this exact value.
- Repeat pulses:
  - The second pulse comes RPT_DLY cycles after the first.
  - Later pulses come every RPT_PER cycles.
- Pulse and release on the same cycle: if a pulse condition and key release occur together, the pulse is still emitted and the state goes to RELEASE.
- EN low (synchronous):
  - Next state is IDLE, the timer clears and outputs go to 0 the next cycle, even mid-DEBOUNCE/HOLD/REPEAT.
  - The synchronisers keep running.
  - When EN rises with a key held, a fresh debounce starts.
- Reset mid-operation: immediate return to reset values; no partial pulse.
- The controller does not track the counter value; bound and clamp handling stays in the counter.

Decomposition:
- Shared package or include: state encoding constants (IDLE, DEBOUNCE, HOLD, REPEAT, RELEASE, 3 bits) and the key index constants (K_ADD1=0 .. K_SUB10=3).
- One natural sub-module, key_sync: 2-flop synchroniser, 4 bits wide, reset to 1.
- FSM, timer and output decode stay in the top.

Test Plan:
Bench uses DB_CYC=4, RPT_DLY=10, RPT_PER=3.
- Single press: KEYX[0]=0 at edge 10, held 8 cycles, then released → exactly one ADD1 pulse after edge 16, no others. BUSY returns low after the release debounce.
- Glitch: KEYX[1] low for 2 cycles only → no pulse; state returns to IDLE.
- Auto-repeat: KEYX[2] held 40 cycles → SUB1 pulses after edges 2+4, +10, then every 3 cycles. Count them and check exact edge numbers.
- Simultaneous press: KEYX=4'b0000 → only ADD1 pulses. Releasing key 0 while the others stay held → no further pulses until all are released and one is re-pressed.
- Release bounce: key 3 released with 1-cycle re-press spikes every 2 cycles → exactly one SUB10 pulse total. IDLE is reached only after 4 clean cycles.
- EN/reset: EN dropped during REPEAT gives no pulse next cycle and BUSY=0. RSTX asserted mid-HOLD zeroes all outputs asynchronously.
